// File: rtl/dp_ram_arbiter_if.sv
// One requester's command/response channel into the dual-port RAM arbiter.
// The requester drives the command side (master); the arbiter returns
// grant, read data and the out-of-range pulse (slave).
interface dp_ram_arbiter_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH_W = 5,
    parameter int ADDR_WIDTH_H = 5
);
    logic                    req;
    logic                    wr;
    logic [ADDR_WIDTH_W-1:0] row;
    logic [ADDR_WIDTH_H-1:0] col;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    gnt;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    err;

    modport master (
        output req, wr, row, col, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, wr, row, col, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dp_ram_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a synchronous dual-port RAM
// with row/column addressing and a registered read port. Accepts one command
// per cycle, registers the RAM pins, and returns read data three edges after
// the transfer (command reg -> RAM read reg -> response reg), tagged to the
// issuing requester. Out-of-range coordinates never touch the RAM and come
// back as an err pulse in the slot the read data would have used.
module dp_ram_arbiter #(
    parameter int          DATA_WIDTH   = 8,
    parameter int          ADDR_WIDTH_W = 5,
    parameter int          ADDR_WIDTH_H = 5,
    parameter int unsigned ROWS         = 5,
    parameter int unsigned COLS         = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dp_ram_arbiter_if.slave         rq0,
    dp_ram_arbiter_if.slave         rq1,
    output logic                    ram_we,
    output logic [DATA_WIDTH-1:0]   ram_data_in,
    output logic [ADDR_WIDTH_W-1:0] ram_read_addr_1,
    output logic [ADDR_WIDTH_H-1:0] ram_read_addr_2,
    output logic [ADDR_WIDTH_W-1:0] ram_write_addr_1,
    output logic [ADDR_WIDTH_H-1:0] ram_write_addr_2,
    input  logic [DATA_WIDTH-1:0]   ram_data_out
);

    // Response tag travelling alongside the RAM read pipeline.
    typedef struct packed {
        logic valid;
        logic req;
        logic err;
    } tag_t;

    // Requester channels flattened into arrays so per-requester logic can be generated.
    logic [1:0]              req_w;
    logic [1:0]              wr_w;
    logic [ADDR_WIDTH_W-1:0] row_w   [2];
    logic [ADDR_WIDTH_H-1:0] col_w   [2];
    logic [DATA_WIDTH-1:0]   wdata_w [2];
    logic [1:0]              in_range_w;
    logic [1:0]              gnt_w;

    logic                    last_reg;
    logic                    ram_we_reg;
    logic [DATA_WIDTH-1:0]   ram_data_in_reg;
    logic [ADDR_WIDTH_W-1:0] rd_row_reg;
    logic [ADDR_WIDTH_H-1:0] rd_col_reg;
    logic [ADDR_WIDTH_W-1:0] wr_row_reg;
    logic [ADDR_WIDTH_H-1:0] wr_col_reg;
    tag_t                    tag1_reg;
    tag_t                    tag2_reg;

    logic                    xfer_w;
    logic                    sel_w;

    assign req_w[0]   = rq0.req;
    assign req_w[1]   = rq1.req;
    assign wr_w[0]    = rq0.wr;
    assign wr_w[1]    = rq1.wr;
    assign row_w[0]   = rq0.row;
    assign row_w[1]   = rq1.row;
    assign col_w[0]   = rq0.col;
    assign col_w[1]   = rq1.col;
    assign wdata_w[0] = rq0.wdata;
    assign wdata_w[1] = rq1.wdata;

    // Unsigned bounds check per requester; computed for both so the selected one is ready.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_range
            assign in_range_w[gi] = (32'(row_w[gi]) < ROWS) && (32'(col_w[gi]) < COLS);
        end
    endgenerate

    // Round-robin grant: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        gnt_w = 2'b00;
        if (req_w[0] && (!req_w[1] || last_reg)) begin
            gnt_w[0] = 1'b1;
        end else if (req_w[1]) begin
            gnt_w[1] = 1'b1;
        end
    end

    assign xfer_w = |gnt_w;
    assign sel_w  = gnt_w[1];

    // Stage 1: register the RAM command pins and launch the response tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg        <= 1'b1;
            ram_we_reg      <= 1'b0;
            ram_data_in_reg <= '0;
            rd_row_reg      <= '0;
            rd_col_reg      <= '0;
            wr_row_reg      <= '0;
            wr_col_reg      <= '0;
            tag1_reg        <= '0;
        end else begin
            ram_we_reg <= 1'b0;
            tag1_reg   <= '0;
            if (xfer_w) begin
                last_reg <= sel_w;
                if (!in_range_w[sel_w]) begin
                    // Leave every RAM pin untouched; only the err response goes out.
                    tag1_reg <= '{valid: 1'b1, req: sel_w, err: 1'b1};
                end else if (wr_w[sel_w]) begin
                    ram_we_reg      <= 1'b1;
                    wr_row_reg      <= row_w[sel_w];
                    wr_col_reg      <= col_w[sel_w];
                    ram_data_in_reg <= wdata_w[sel_w];
                end else begin
                    rd_row_reg <= row_w[sel_w];
                    rd_col_reg <= col_w[sel_w];
                    tag1_reg   <= '{valid: 1'b1, req: sel_w, err: 1'b0};
                end
            end
        end
    end

    // Stage 2: delay the tag while the RAM samples the read address into its output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag2_reg <= '0;
        end else begin
            tag2_reg <= tag1_reg;
        end
    end

    // Stage 3: per-requester response registers, steered by the delayed tag.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_resp
            logic                  rvalid_reg;
            logic                  err_reg;
            logic [DATA_WIDTH-1:0] rdata_reg;
            logic                  mine_w;

            assign mine_w = tag2_reg.valid && (tag2_reg.req == 1'(gi));

            // Capture RAM output for this requester's reads; rdata holds on err.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rvalid_reg <= 1'b0;
                    err_reg    <= 1'b0;
                    rdata_reg  <= '0;
                end else begin
                    rvalid_reg <= mine_w && !tag2_reg.err;
                    err_reg    <= mine_w && tag2_reg.err;
                    if (mine_w && !tag2_reg.err) begin
                        rdata_reg <= ram_data_out;
                    end
                end
            end
        end
    endgenerate

    assign rq0.gnt    = gnt_w[0];
    assign rq1.gnt    = gnt_w[1];
    assign rq0.rvalid = gen_resp[0].rvalid_reg;
    assign rq1.rvalid = gen_resp[1].rvalid_reg;
    assign rq0.err    = gen_resp[0].err_reg;
    assign rq1.err    = gen_resp[1].err_reg;
    assign rq0.rdata  = gen_resp[0].rdata_reg;
    assign rq1.rdata  = gen_resp[1].rdata_reg;

    assign ram_we           = ram_we_reg;
    assign ram_data_in      = ram_data_in_reg;
    assign ram_read_addr_1  = rd_row_reg;
    assign ram_read_addr_2  = rd_col_reg;
    assign ram_write_addr_1 = wr_row_reg;
    assign ram_write_addr_2 = wr_col_reg;

endmodule

// File: tb/tb_dp_ram_arbiter.sv
// Bench for dp_ram_arbiter: behavioural dual-port RAM with registered read,
// a reference model of grants/RAM contents, and a scoreboard of expected
// responses keyed by the cycle they are due.
module tb_dp_ram_arbiter;
    localparam int DW   = 8;
    localparam int AW   = 5;
    localparam int AH   = 5;
    localparam int ROWS = 5;
    localparam int COLS = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    dp_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH_W(AW), .ADDR_WIDTH_H(AH)) rq0 ();
    dp_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH_W(AW), .ADDR_WIDTH_H(AH)) rq1 ();

    logic          ram_we;
    logic [DW-1:0] ram_data_in;
    logic [AW-1:0] ram_read_addr_1;
    logic [AH-1:0] ram_read_addr_2;
    logic [AW-1:0] ram_write_addr_1;
    logic [AH-1:0] ram_write_addr_2;
    logic [DW-1:0] ram_data_out;

    dp_ram_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH_W(AW), .ADDR_WIDTH_H(AH), .ROWS(ROWS), .COLS(COLS)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rq0              (rq0),
        .rq1              (rq1),
        .ram_we           (ram_we),
        .ram_data_in      (ram_data_in),
        .ram_read_addr_1  (ram_read_addr_1),
        .ram_read_addr_2  (ram_read_addr_2),
        .ram_write_addr_1 (ram_write_addr_1),
        .ram_write_addr_2 (ram_write_addr_2),
        .ram_data_out     (ram_data_out)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: write port plus registered read port.
    logic [DW-1:0] mem [0:(1<<AW)-1][0:(1<<AH)-1];
    always @(posedge clk) begin
        if (ram_we) mem[ram_write_addr_1][ram_write_addr_2] <= ram_data_in;
        ram_data_out <= mem[ram_read_addr_1][ram_read_addr_2];
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int            due;
        int            k;
        bit            err;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference model state
    logic [DW-1:0] ref_mem [0:(1<<AW)-1][0:(1<<AH)-1];
    logic          last_m;
    logic          exp_we, exp_rd;
    logic [AW-1:0] exp_r;
    logic [AH-1:0] exp_c;
    logic [DW-1:0] exp_d;
    logic [DW-1:0] exp_rdata [2];

    // Monitor: compares outputs, then records the transfer for the coming edge.
    initial begin
        exp_t          e;
        logic          eg0, eg1, w, inr, k;
        logic [AW-1:0] r;
        logic [AH-1:0] c;
        logic [DW-1:0] d;
        logic          gv [2];
        logic          ge [2];
        logic [DW-1:0] gd [2];
        last_m = 1'b1; exp_we = 1'b0; exp_rd = 1'b0;
        exp_r = '0; exp_c = '0; exp_d = '0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        forever begin
            @(negedge clk);
            gv[0] = rq0.rvalid; gv[1] = rq1.rvalid;
            ge[0] = rq0.err;    ge[1] = rq1.err;
            gd[0] = rq0.rdata;  gd[1] = rq1.rdata;
            if (!rst_n) begin
                check_eq("rst_pulses", {gv[1], gv[0], ge[1], ge[0]}, 4'b0);
                check_eq("rst_rdata", {gd[1], gd[0]}, '0);
                check_eq("rst_ram_we", ram_we, 1'b0);
                check_eq("rst_ram_pins", {ram_read_addr_1, ram_read_addr_2, ram_write_addr_1,
                         ram_write_addr_2, ram_data_in}, '0);
                sb.delete();
                last_m = 1'b1; exp_we = 1'b0; exp_rd = 1'b0;
                exp_rdata[0] = '0; exp_rdata[1] = '0;
            end else begin
                if (sb.size() > 0 && sb[0].due < cyc) begin
                    e = sb.pop_front();
                    check_eq("lost_response", 0, 1);
                end
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    e = sb.pop_front();
                    check_eq($sformatf("rvalid%0d", e.k), gv[e.k], !e.err);
                    check_eq($sformatf("err%0d", e.k), ge[e.k], e.err);
                    check_eq($sformatf("other_quiet%0d", 1 - e.k), {gv[1-e.k], ge[1-e.k]}, 2'b0);
                    if (!e.err) exp_rdata[e.k] = e.data;
                    check_eq($sformatf("rdata%0d", e.k), gd[e.k], exp_rdata[e.k]);
                end else begin
                    check_eq("idle_pulses", {gv[1], gv[0], ge[1], ge[0]}, 4'b0);
                end
                check_eq("ram_we", ram_we, exp_we);
                if (exp_we)
                    check_eq("ram_wr_pins", {ram_write_addr_1, ram_write_addr_2, ram_data_in},
                             {exp_r, exp_c, exp_d});
                if (exp_rd)
                    check_eq("ram_rd_pins", {ram_read_addr_1, ram_read_addr_2}, {exp_r, exp_c});

                eg0 = rq0.req && (!rq1.req || last_m);
                eg1 = rq1.req && (!rq0.req || !last_m);
                check_eq("gnt", {rq1.gnt, rq0.gnt}, {eg1, eg0});
                exp_we = 1'b0; exp_rd = 1'b0;
                if (eg0 || eg1) begin
                    k = eg1;
                    w = k ? rq1.wr : rq0.wr;
                    r = k ? rq1.row : rq0.row;
                    c = k ? rq1.col : rq0.col;
                    d = k ? rq1.wdata : rq0.wdata;
                    inr = (int'(r) < ROWS) && (int'(c) < COLS);
                    last_m = k;
                    e.due = cyc + 3; e.k = int'(k); e.err = !inr; e.data = '0;
                    if (inr) begin
                        exp_r = r; exp_c = c;
                        if (w) begin
                            exp_we = 1'b1; exp_d = d;
                            ref_mem[r][c] = d;
                        end else begin
                            exp_rd = 1'b1;
                            e.data = ref_mem[r][c];
                            sb.push_back(e);
                        end
                    end else begin
                        sb.push_back(e);
                    end
                end
            end
        end
    end

    task automatic set_cmd(input int k, input bit req, input bit w, input int r, input int c,
                           input int d);
        if (k == 0) begin
            rq0.req = req; rq0.wr = w; rq0.row = AW'(r); rq0.col = AH'(c); rq0.wdata = DW'(d);
        end else begin
            rq1.req = req; rq1.wr = w; rq1.row = AW'(r); rq1.col = AH'(c); rq1.wdata = DW'(d);
        end
    endtask

    // Drive one command and hold it until it transfers (bounded wait).
    task automatic issue(input int k, input bit w, input int r, input int c, input int d);
        bit done;
        done = 1'b0;
        set_cmd(k, 1'b1, w, r, c, d);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = (k == 0) ? rq0.gnt : rq1.gnt;
        end
        if (!done) check_eq("grant_timeout", 0, 1);
        @(posedge clk);
        #1;
        set_cmd(k, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        set_cmd(0, 1'b0, 1'b0, 0, 0, 0);
        set_cmd(1, 1'b0, 1'b0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // Write then read, one requester
        issue(0, 1'b1, 2, 3, 8'hA5);
        issue(0, 1'b0, 2, 3, 0);
        idle(4);

        // Round robin under contention, distinct cells per requester
        issue(0, 1'b1, 1, 1, 8'h11);
        issue(1, 1'b1, 1, 2, 8'h22);
        set_cmd(0, 1'b1, 1'b0, 1, 1, 0);
        set_cmd(1, 1'b1, 1'b0, 1, 2, 0);
        idle(6);
        set_cmd(0, 1'b0, 1'b0, 0, 0, 0);
        set_cmd(1, 1'b0, 1'b0, 0, 0, 0);
        idle(4);

        // Cross-requester write then read of the same cell
        issue(0, 1'b1, 0, 0, 8'h55);
        issue(1, 1'b1, 0, 0, 8'h3C);
        issue(0, 1'b0, 0, 0, 0);
        idle(4);

        // Range checks and boundaries
        issue(0, 1'b0, ROWS, 0, 0);
        issue(0, 1'b1, ROWS - 1, COLS - 1, 8'h44);
        issue(0, 1'b1, 4, 7, 8'h77);
        issue(0, 1'b0, ROWS - 1, COLS - 1, 0);
        issue(1, 1'b0, 31, 31, 0);
        issue(1, 1'b1, 0, COLS, 8'h99);
        issue(1, 1'b0, 0, 0, 0);
        idle(5);

        // Reset with a read in flight
        issue(0, 1'b0, 2, 3, 0);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(4);
        set_cmd(0, 1'b1, 1'b0, 2, 3, 0);
        set_cmd(1, 1'b1, 1'b0, 1, 2, 0);
        @(negedge clk);
        check_eq("tie_after_rst", {rq1.gnt, rq0.gnt}, 2'b01);
        @(posedge clk);
        #1;
        idle(1);
        set_cmd(0, 1'b0, 1'b0, 0, 0, 0);
        set_cmd(1, 1'b0, 1'b0, 0, 0, 0);
        idle(5);
        check_eq("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
